// File: rtl/pipe_mem_pkg.sv
// Shared types and helpers for the MEM pipeline stage: memory op encoding,
// alignment checks, store lane/data formation and load lane extraction.
package pipe_mem_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        MEM_LB   = 4'd1,
        MEM_LBU  = 4'd2,
        MEM_LH   = 4'd3,
        MEM_LHU  = 4'd4,
        MEM_LW   = 4'd5,
        MEM_SB   = 4'd6,
        MEM_SH   = 4'd7,
        MEM_SW   = 4'd8
    } mem_op_t;

    localparam int WORD_W  = 32;
    localparam int LANES   = WORD_W / 8;

    function automatic logic is_load(mem_op_t op);
        return op inside {MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW};
    endfunction

    function automatic logic is_store(mem_op_t op);
        return op inside {MEM_SB, MEM_SH, MEM_SW};
    endfunction

    function automatic logic misaligned(mem_op_t op, logic [1:0] off);
        case (op)
            MEM_LH, MEM_LHU, MEM_SH: return off[0];
            MEM_LW, MEM_SW:          return |off;
            default:                 return 1'b0;
        endcase
    endfunction

    function automatic logic [LANES-1:0] store_lanes(mem_op_t op, logic [1:0] off);
        case (op)
            MEM_SB:  return 4'b0001 << off;
            MEM_SH:  return off[1] ? 4'b1100 : 4'b0011;
            MEM_SW:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    // Replicate the sub-word so whichever lane is enabled sees the right bits.
    function automatic logic [WORD_W-1:0] store_data(mem_op_t op, logic [WORD_W-1:0] sdata);
        case (op)
            MEM_SB:  return {4{sdata[7:0]}};
            MEM_SH:  return {2{sdata[15:0]}};
            default: return sdata;
        endcase
    endfunction

    function automatic logic [WORD_W-1:0] load_extract(logic [WORD_W-1:0] word, mem_op_t op,
                                                       logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*off +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (op)
            MEM_LB:  return {{24{b[7]}}, b};
            MEM_LBU: return {24'd0, b};
            MEM_LH:  return {{16{h[15]}}, h};
            MEM_LHU: return {16'd0, h};
            default: return word;
        endcase
    endfunction

endpackage

// File: rtl/pipe_dmem_ram.sv
// Single-port synchronous data RAM with per-byte write enables and a
// registered read port that only updates when the read enable is set.
module pipe_dmem_ram
    import pipe_mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clock,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [LANES-1:0]      wen,
    input  logic [WORD_W-1:0]     wdata,
    input  logic                  ren,
    output logic [WORD_W-1:0]     rdata
);

    logic [WORD_W-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        for (int b = 0; b < LANES; b++) begin
            if (wen[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        if (ren) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/pipe_mem_stage.sv
// MEM stage: sub-word loads/stores against the data RAM, one-cycle registered
// MEM/WB bundle with valid/ready handshake and a misalignment flag.
module pipe_mem_stage
    import pipe_mem_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int REG_W      = 5
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  mem_op_t           in_op,
    input  logic [DATA_W-1:0] in_alu,
    input  logic [DATA_W-1:0] in_sdata,
    input  logic              in_wreg,
    input  logic [REG_W-1:0]  in_rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_wreg,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_exc
);

    if (DATA_W != WORD_W) begin : g_width_check
        $error("pipe_mem_stage supports only DATA_W == 32");
    end

    logic                  accept;
    logic [1:0]            off;
    logic                  mis;
    logic [DEPTH_LOG2-1:0] ram_addr;
    logic [LANES-1:0]      ram_wen;
    logic                  ram_ren;
    logic [DATA_W-1:0]     ram_wdata;
    logic [DATA_W-1:0]     ram_rdata;

    logic [DATA_W-1:0]     alu_q;
    mem_op_t               op_q;
    logic [1:0]            off_q;

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign off       = in_alu[1:0];
    assign mis       = misaligned(in_op, off);
    assign ram_addr  = in_alu[DEPTH_LOG2+1:2];
    assign ram_wdata = store_data(in_op, in_sdata);
    assign ram_wen   = (accept && !mis) ? store_lanes(in_op, off) : '0;
    assign ram_ren   = accept && !mis && is_load(in_op);

    pipe_dmem_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clock (clock),
        .addr  (ram_addr),
        .wen   (ram_wen),
        .wdata (ram_wdata),
        .ren   (ram_ren),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_wreg  <= 1'b0;
            out_rd    <= '0;
            out_exc   <= 1'b0;
            alu_q     <= '0;
            op_q      <= MEM_NONE;
            off_q     <= 2'd0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_wreg  <= in_wreg && !is_store(in_op) && !mis;
            out_rd    <= in_rd;
            out_exc   <= mis;
            alu_q     <= in_alu;
            op_q      <= in_op;
            off_q     <= off;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Lane extraction sits after the RAM output register, driven only by state.
    always_comb begin
        out_data = alu_q;
        if (out_exc) begin
            out_data = '0;
        end else if (is_load(op_q)) begin
            out_data = load_extract(ram_rdata, op_q, off_q);
        end
    end

endmodule

// File: tb/tb_pipe_mem_stage.sv
// Directed self-checking bench for pipe_mem_stage.
module tb_pipe_mem_stage;
    import pipe_mem_pkg::*;

    logic        clock;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    mem_op_t     in_op;
    logic [31:0] in_alu;
    logic [31:0] in_sdata;
    logic        in_wreg;
    logic [4:0]  in_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_wreg;
    logic [4:0]  out_rd;
    logic        out_exc;

    int tests = 0;
    int fails = 0;

    pipe_mem_stage #(
        .DATA_W     (32),
        .DEPTH_LOG2 (10),
        .REG_W      (5)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_alu    (in_alu),
        .in_sdata  (in_sdata),
        .in_wreg   (in_wreg),
        .in_rd     (in_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_wreg  (out_wreg),
        .out_rd    (out_rd),
        .out_exc   (out_exc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                          input logic w, input logic [4:0] rd);
        in_op    = op;
        in_alu   = a;
        in_sdata = d;
        in_wreg  = w;
        in_rd    = rd;
        in_valid = 1'b1;
    endtask

    task automatic send(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                        input logic w, input logic [4:0] rd);
        set_in(op, a, d, w, rd);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] data, input logic w,
                           input logic exc);
        chk({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, ".data"},  out_data, data);
        chk({tag, ".wreg"},  {31'd0, out_wreg}, {31'd0, w});
        chk({tag, ".exc"},   {31'd0, out_exc}, {31'd0, exc});
    endtask

    task automatic idle();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_op     = MEM_NONE;
        in_alu    = '0;
        in_sdata  = '0;
        in_wreg   = 1'b0;
        in_rd     = '0;

        #12;
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        chk("rst.data",  out_data, 32'd0);
        chk("rst.wreg",  {31'd0, out_wreg}, 32'd0);
        chk("rst.rd",    {27'd0, out_rd}, 32'd0);
        chk("rst.exc",   {31'd0, out_exc}, 32'd0);
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clock);
        #1;
        resetn = 1'b1;
        idle();

        send(MEM_SW, 32'h40, 32'h12345678, 1'b0, 5'd0);
        chk_out("sw40", 32'h40, 1'b0, 1'b0);
        send(MEM_LW, 32'h40, 32'h0, 1'b1, 5'd5);
        chk_out("lw40", 32'h12345678, 1'b1, 1'b0);
        chk("lw40.rd", {27'd0, out_rd}, 32'd5);

        send(MEM_SB, 32'h41, 32'hFFFFFFAB, 1'b0, 5'd0);
        send(MEM_LW, 32'h40, 32'h0, 1'b1, 5'd6);
        chk_out("sb41.lw", 32'h1234AB78, 1'b1, 1'b0);
        send(MEM_LB, 32'h41, 32'h0, 1'b1, 5'd7);
        chk_out("lb41", 32'hFFFFFFAB, 1'b1, 1'b0);
        send(MEM_LBU, 32'h41, 32'h0, 1'b1, 5'd8);
        chk_out("lbu41", 32'h000000AB, 1'b1, 1'b0);
        send(MEM_LBU, 32'h40, 32'h0, 1'b1, 5'd8);
        chk_out("lbu40", 32'h00000078, 1'b1, 1'b0);

        send(MEM_SH, 32'h42, 32'h55558001, 1'b0, 5'd0);
        send(MEM_LH, 32'h42, 32'h0, 1'b1, 5'd9);
        chk_out("lh42", 32'hFFFF8001, 1'b1, 1'b0);
        send(MEM_LHU, 32'h42, 32'h0, 1'b1, 5'd9);
        chk_out("lhu42", 32'h00008001, 1'b1, 1'b0);
        send(MEM_LH, 32'h40, 32'h0, 1'b1, 5'd9);
        chk_out("lh40", 32'hFFFFAB78, 1'b1, 1'b0);

        send(MEM_LW, 32'h43, 32'h0, 1'b1, 5'd10);
        chk_out("lw43.exc", 32'h0, 1'b0, 1'b1);
        send(MEM_SH, 32'h41, 32'hFFFFFFFF, 1'b1, 5'd11);
        chk_out("sh41.exc", 32'h0, 1'b0, 1'b1);
        send(MEM_SW, 32'h42, 32'h0, 1'b0, 5'd0);
        chk_out("sw42.exc", 32'h0, 1'b0, 1'b1);
        send(MEM_LW, 32'h40, 32'h0, 1'b1, 5'd12);
        chk_out("exc.unchanged", 32'h8001AB78, 1'b1, 1'b0);

        send(MEM_NONE, 32'hDEADBEEF, 32'h0, 1'b1, 5'd13);
        chk_out("none", 32'hDEADBEEF, 1'b1, 1'b0);
        chk("none.rd", {27'd0, out_rd}, 32'd13);

        send(MEM_SW, 32'h1080, 32'hCAFEF00D, 1'b0, 5'd0);
        send(MEM_LW, 32'h80, 32'h0, 1'b1, 5'd14);
        chk_out("wrap", 32'hCAFEF00D, 1'b1, 1'b0);

        idle();
        chk("drop.valid", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        send(MEM_LW, 32'h80, 32'h0, 1'b1, 5'd1);
        chk_out("stall.first", 32'hCAFEF00D, 1'b1, 1'b0);
        set_in(MEM_LW, 32'h40, 32'h0, 1'b1, 5'd2);
        #1;
        chk("stall.in_ready", {31'd0, in_ready}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("stall.hold.data", out_data, 32'hCAFEF00D);
            chk("stall.hold.rd", {27'd0, out_rd}, 32'd1);
            chk("stall.hold.valid", {31'd0, out_valid}, 32'd1);
            chk("stall.hold.in_ready", {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", {31'd0, in_ready}, 32'd1);
        idle();
        chk_out("b2b.second", 32'h8001AB78, 1'b1, 1'b0);
        chk("b2b.second.rd", {27'd0, out_rd}, 32'd2);
        set_in(MEM_LW, 32'h80, 32'h0, 1'b1, 5'd3);
        idle();
        chk_out("b2b.third", 32'hCAFEF00D, 1'b1, 1'b0);
        chk("b2b.third.rd", {27'd0, out_rd}, 32'd3);
        in_valid = 1'b0;
        idle();
        chk("b2b.drain", {31'd0, out_valid}, 32'd0);

        out_ready = 1'b0;
        send(MEM_LW, 32'h40, 32'h0, 1'b1, 5'd4);
        chk("rst2.pre.valid", {31'd0, out_valid}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("rst2.valid", {31'd0, out_valid}, 32'd0);
        chk("rst2.data", out_data, 32'd0);
        chk("rst2.rd", {27'd0, out_rd}, 32'd0);
        idle();
        resetn    = 1'b1;
        out_ready = 1'b1;
        idle();
        send(MEM_LW, 32'h80, 32'h0, 1'b1, 5'd6);
        chk_out("rst2.lw80", 32'hCAFEF00D, 1'b1, 1'b0);
        send(MEM_LW, 32'h40, 32'h0, 1'b1, 5'd6);
        chk_out("rst2.lw40", 32'h8001AB78, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
